cac_wb_slice: RTL

Cache-to-memory writeback sequencer for one 9-bit cache data slice (bits 18–26 plus parity). On a writeback request it walks the four words of a cache line in the selected way, reads each word from the slice's RAM, optionally checks parity and presents each word to memory under a valid/ready handshake. It is the outbound counterpart of the memory-to-cache fill path on the same cache data slice.

---
 rtl/cac_wb_slice.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cac_wb_slice.sv
// cac_wb_slice: cache-to-memory writeback sequencer for one 9-bit cache data
// slice (bits 18-26 plus parity). A writeback request walks the four words of
// the selected way's line, reading each from the slice RAM and presenting it
// to memory under a valid/ready handshake.
//
// Optional feature macro: CAC_WB_PAR_CHK_EN
//   defined   - odd parity over data+parity is checked on every RAM read;
//               an even count sets the sticky par_err_h flag.
//   undefined - no checker; par_err_h is tied low. Parity is always passed
//               through to memory unchanged.
//
// Memory handshake: cache_to_mem_val_h is high for the whole SEND state and
// the word is transferred on any rising edge where both cache_to_mem_val_h
// and mem_rdy_h are high. While val is high and ready is low, data, parity
// and the word address are held stable; val never drops without a transfer
// except on reset.
module cac_wb_slice (
  input  logic       clk_h,
  input  logic       reset_h,
  input  logic       wb_req_h,
  input  logic [1:0] wb_way_h,
  input  logic [6:0] wb_line_adr_h,
  output logic       wb_busy_h,
  output logic       wb_done_h,
  output logic [6:0] cache_adr_27_33_h,
  output logic       cache_adr_34_h,
  output logic       cache_adr_35_h,
  output logic       cache_adr_35_l,
  output logic [3:0] csh_sel_l,
  input  logic [8:0] cache_data_h,
  input  logic       csh_par_bit_h,
  output logic [8:0] cache_to_mem_h,
  output logic       cache_to_mem_par_h,
  output logic       cache_to_mem_val_h,
  input  logic       mem_rdy_h,
  output logic       par_err_h
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADR  = 2'd1,
    ST_RD   = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] way_q;
  logic [6:0] line_q;
  logic [1:0] cnt_q;
  logic [8:0] hold_data_q;
  logic       hold_par_q;
  logic       done_q;

  logic       accept;
  logic       handshake;
  logic       last_word;

  assign accept    = (state_q == ST_IDLE) && wb_req_h;
  assign handshake = (state_q == ST_SEND) && mem_rdy_h;
  assign last_word = (cnt_q == 2'd3);

  // State register.
  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one address cycle, one RAM read cycle, then hold until memory takes the word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (wb_req_h) state_d = ST_ADR;
      ST_ADR:  state_d = ST_RD;
      ST_RD:   state_d = ST_SEND;
      ST_SEND: begin
        if (mem_rdy_h) begin
          state_d = last_word ? ST_IDLE : ST_ADR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs: way select only during the address cycle, valid only while sending.
  always_comb begin
    wb_busy_h          = (state_q != ST_IDLE);
    cache_to_mem_val_h = (state_q == ST_SEND);
    csh_sel_l          = 4'b1111;
    if (state_q == ST_ADR) begin
      csh_sel_l = ~(4'b0001 << way_q);
    end
  end

  // Request latch, word counter, holding register and done pulse.
  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      way_q       <= 2'd0;
      line_q      <= 7'd0;
      cnt_q       <= 2'd0;
      hold_data_q <= 9'd0;
      hold_par_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= handshake && last_word;
      if (accept) begin
        way_q  <= wb_way_h;
        line_q <= wb_line_adr_h;
        cnt_q  <= 2'd0;
      end else if (handshake && !last_word) begin
        // Counter stops at 3 so it never wraps inside one writeback.
        cnt_q <= cnt_q + 2'd1;
      end
      if (state_q == ST_RD) begin
        hold_data_q <= cache_data_h;
        hold_par_q  <= csh_par_bit_h;
      end
    end
  end

`ifdef CAC_WB_PAR_CHK_EN
  logic par_bad;
  logic par_err_q;

  // Odd parity expected over 9 data bits plus the parity bit.
  assign par_bad = ~(^{cache_data_h, csh_par_bit_h});

  // Sticky error: set by any bad read, cleared only by a new accept or reset.
  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      par_err_q <= 1'b0;
    end else if (accept) begin
      par_err_q <= 1'b0;
    end else if ((state_q == ST_RD) && par_bad) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err_h = par_err_q;
`else
  assign par_err_h = 1'b0;
`endif

  assign wb_done_h          = done_q;
  assign cache_adr_27_33_h  = line_q;
  assign cache_adr_34_h     = cnt_q[1];
  assign cache_adr_35_h     = cnt_q[0];
  assign cache_adr_35_l     = ~cnt_q[0];
  assign cache_to_mem_h     = hold_data_q;
  assign cache_to_mem_par_h = hold_par_q;

endmodule
